// File: rtl/fnd_scan_apb.sv
// APB seven-segment scan controller: hex/decimal display, leading-zero blanking, DP, overflow dash.
// Optional per-digit blinking is compiled in when FND_BLINK_EN is defined.
module fnd_scan_apb #(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_W      = 14,
    parameter int SCAN_DIV   = 100000
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic [4:0]            PADDR,
    input  logic                  PWRITE,
    input  logic                  PENABLE,
    input  logic                  PSEL,
    input  logic [31:0]           PWDATA,
    output logic [31:0]           PRDATA,
    output logic                  PREADY,
    output logic [7:0]            fnd_data,
    output logic [NUM_DIGITS-1:0] fnd_com
);

    localparam int NBCD  = NUM_DIGITS + 1;
    localparam int BCD_W = 4 * NBCD;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SH_W  = $clog2(BIN_W + 1);

    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SH_W-1:0]  LAST_SHIFT = SH_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LOAD  = 2'd2
    } state_t;

    function automatic logic [7:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 8'hC0;
            4'h1: glyph = 8'hF9;
            4'h2: glyph = 8'hA4;
            4'h3: glyph = 8'hB0;
            4'h4: glyph = 8'h99;
            4'h5: glyph = 8'h92;
            4'h6: glyph = 8'h82;
            4'h7: glyph = 8'hF8;
            4'h8: glyph = 8'h80;
            4'h9: glyph = 8'h90;
            4'hA: glyph = 8'h88;
            4'hB: glyph = 8'h83;
            4'hC: glyph = 8'hC6;
            4'hD: glyph = 8'hA1;
            4'hE: glyph = 8'h86;
            default: glyph = 8'h8E;
        endcase
    endfunction

    // APB: a transfer is accepted on the edge where PSEL & PENABLE are high and
    // PREADY is still low; that same edge raises PREADY for exactly one cycle.
    logic        pready_q;
    logic [31:0] prdata_q;
    logic        access;
    logic        wr;
    logic        rd;
    logic [2:0]  sel;
    logic        wr_ctrl;
    logic        wr_data;
    logic        wr_dp;
    logic        unused_addr;

    assign access      = PSEL & PENABLE & ~pready_q;
    assign wr          = access & PWRITE;
    assign rd          = access & ~PWRITE;
    assign sel         = PADDR[4:2];
    assign wr_ctrl     = wr & (sel == 3'd0);
    assign wr_data     = wr & (sel == 3'd1);
    assign wr_dp       = wr & (sel == 3'd2);
    assign unused_addr = ^PADDR[1:0];

    logic [2:0]            ctrl_q;
    logic [31:0]           data_q;
    logic [NUM_DIGITS-1:0] dp_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ctrl_q <= '0;
            data_q <= '0;
            dp_q   <= '0;
        end else begin
            if (wr_ctrl) ctrl_q <= PWDATA[2:0];
            if (wr_data) data_q <= PWDATA;
            if (wr_dp)   dp_q   <= PWDATA[NUM_DIGITS-1:0];
        end
    end

    // Decimal converter: shift-add-3 over BIN_W cycles, then one LOAD cycle.
    state_t                state_q, state_d;
    logic [BIN_W-1:0]      bin_q, bin_d;
    logic [BCD_W-1:0]      bcd_q, bcd_d;
    logic [BCD_W-1:0]      adj;
    logic [SH_W-1:0]       shcnt_q, shcnt_d;
    logic                  sticky_q, sticky_d;
    logic                  load;
    logic                  busy;
    logic                  mode_rise;
    logic                  mode_fall;
    logic                  conv_start;
    logic [BIN_W-1:0]      start_val;

    assign mode_rise  = wr_ctrl & PWDATA[1] & ~ctrl_q[1];
    assign mode_fall  = wr_ctrl & ~PWDATA[1] & ctrl_q[1];
    assign conv_start = (wr_data & ctrl_q[1]) | mode_rise;
    assign start_val  = wr_data ? PWDATA[BIN_W-1:0] : data_q[BIN_W-1:0];
    assign busy       = (state_q != S_IDLE);

    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        shcnt_d  = shcnt_q;
        sticky_d = sticky_q;
        load     = 1'b0;
        adj      = bcd_q;
        for (int i = 0; i < NBCD; i++) begin
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        case (state_q)
            S_SHIFT: begin
                bcd_d    = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
                bin_d    = bin_q << 1;
                sticky_d = sticky_q | adj[BCD_W-1];
                shcnt_d  = shcnt_q + 1'b1;
                if (shcnt_q == LAST_SHIFT) state_d = S_LOAD;
            end
            S_LOAD: begin
                load    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A new start or a switch back to hex abandons whatever is in flight.
        if (conv_start) begin
            state_d  = S_SHIFT;
            bin_d    = start_val;
            bcd_d    = '0;
            shcnt_d  = '0;
            sticky_d = 1'b0;
            load     = 1'b0;
        end else if (mode_fall) begin
            state_d = S_IDLE;
            load    = 1'b0;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= S_IDLE;
            bin_q    <= '0;
            bcd_q    <= '0;
            shcnt_q  <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            shcnt_q  <= shcnt_d;
            sticky_q <= sticky_d;
        end
    end

    logic [4*NUM_DIGITS-1:0] buf_q;
    logic                    ovf_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            buf_q <= '0;
            ovf_q <= 1'b0;
        end else if (load) begin
            buf_q <= bcd_q[4*NUM_DIGITS-1:0];
            ovf_q <= sticky_q | (bcd_q[BCD_W-1 -: 4] != 4'd0);
        end
    end

    // Digit scan
    logic [PRE_W-1:0] pre_q;
    logic [IDX_W-1:0] idx_q;
    logic             en;
    logic             pre_tc;

    assign en     = ctrl_q[0];
    assign pre_tc = en & (pre_q == PRE_LAST);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            pre_q <= '0;
            idx_q <= '0;
        end else if (!en) begin
            pre_q <= '0;
            idx_q <= '0;
        end else if (pre_tc) begin
            pre_q <= '0;
            idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

    logic        blink_off;
    logic [31:0] blink_rdata;

`ifdef FND_BLINK_EN
    logic [NUM_DIGITS-1:0] blink_mask_q;
    logic [15:0]           blink_half_q;
    logic [15:0]           frame_cnt_q;
    logic                  blink_phase_q;
    logic                  wr_blink;
    logic                  frame_tick;

    assign wr_blink   = wr & (sel == 3'd4);
    assign frame_tick = pre_tc & (idx_q == IDX_LAST);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            blink_mask_q  <= '0;
            blink_half_q  <= '0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (wr_blink) begin
            blink_mask_q  <= PWDATA[NUM_DIGITS-1:0];
            blink_half_q  <= PWDATA[31:16];
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_half_q == 16'd0) begin
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (frame_tick) begin
            if (frame_cnt_q == blink_half_q - 16'd1) begin
                frame_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign blink_off   = blink_phase_q & blink_mask_q[idx_q];
    assign blink_rdata = {blink_half_q, 16'(blink_mask_q)};
`else
    assign blink_off   = 1'b0;
    assign blink_rdata = 32'd0;
`endif

    // Pattern for the digit currently being scanned
    logic [NUM_DIGITS-1:0][3:0] nib;
    logic [NUM_DIGITS-1:0]      blank;
    logic                       nz_seen;
    logic [7:0]                 pat;

    always_comb begin
        nib     = '0;
        blank   = '0;
        nz_seen = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nib[i]   = ctrl_q[1] ? buf_q[4*i +: 4] : data_q[4*i +: 4];
            nz_seen  = nz_seen | (nib[i] != 4'd0);
            blank[i] = ctrl_q[2] & ~nz_seen & (i != 0);
        end
        pat = glyph(nib[idx_q]);
        if (ctrl_q[1] && ovf_q) pat = 8'hBF;
        else if (blank[idx_q])  pat = 8'hFF;
        if (dp_q[idx_q]) pat[7] = 1'b0;
        if (blink_off)   pat = 8'hFF;
    end

    logic [7:0]            fnd_data_q;
    logic [NUM_DIGITS-1:0] fnd_com_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            fnd_data_q <= 8'hFF;
            fnd_com_q  <= '1;
        end else if (!en) begin
            fnd_data_q <= 8'hFF;
            fnd_com_q  <= '1;
        end else begin
            fnd_data_q <= pat;
            fnd_com_q  <= ~(NUM_DIGITS'(1) << idx_q);
        end
    end

    logic [31:0] rdata;

    always_comb begin
        rdata = 32'd0;
        case (sel)
            3'd0: rdata = {29'd0, ctrl_q};
            3'd1: rdata = data_q;
            3'd2: rdata = 32'(dp_q);
            3'd3: rdata = {25'd0, 3'(idx_q), 2'b00, ovf_q, busy};
            3'd4: rdata = blink_rdata;
            default: rdata = 32'd0;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            pready_q <= 1'b0;
            prdata_q <= '0;
        end else begin
            pready_q <= PSEL & PENABLE & ~pready_q;
            if (rd) prdata_q <= rdata;
        end
    end

    assign PREADY   = pready_q;
    assign PRDATA   = prdata_q;
    assign fnd_data = fnd_data_q;
    assign fnd_com  = fnd_com_q;

endmodule
